// File: rtl/core_hazard_pkg.sv
// Shared definitions for the core hazard/forwarding logic: select encodings,
// default register address width and the fence drain state type.
package core_hazard_pkg;

   localparam int unsigned REG_AW_DEF = 5;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_M    = 2'b01;
   localparam logic [1:0] FWD_W    = 2'b10;

   typedef enum logic [0:0] {
      StRun,
      StDrain
   } fence_state_e;

   // M is the younger producer, so it wins over W.
   function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
      if (m_hit) return FWD_M;
      if (w_hit) return FWD_W;
      return FWD_NONE;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-register scoreboard for long-latency writers, outstanding counter,
// sticky retire-error flag and the fence drain FSM.
module hazard_scoreboard
   import core_hazard_pkg::*;
#(
   parameter int unsigned REG_AW  = REG_AW_DEF,
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_i,
   input  logic [REG_AW-1:0] issue_rd_i,
   input  logic              retire_i,
   input  logic [REG_AW-1:0] retire_rd_i,
   input  logic              fence_req_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   output logic              pend_rs1_o,
   output logic              pend_rs2_o,
   output logic              pend_rd_o,
   output logic              drain_o,
   output logic              sb_full_o,
   output logic [CNT_W-1:0]  outstanding_o,
   output logic              sb_err_o
);

   localparam int unsigned      NumRegs = 2 ** REG_AW;
   localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_OUT);

   logic [NumRegs-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   fence_state_e       state_q, state_d;
   logic               issue_ok, retire_ok, cnt_zero;

   always_comb begin
      cnt_zero  = (cnt_q == '0);
      issue_ok  = issue_i & (issue_rd_i != '0);
      retire_ok = retire_i & pending_q[retire_rd_i] & ~cnt_zero;

      // Clear before set so a same-register issue/retire leaves the bit pending.
      pending_d = pending_q;
      if (retire_ok) pending_d[retire_rd_i] = 1'b0;
      if (issue_ok) pending_d[issue_rd_i] = 1'b1;
      pending_d[0] = 1'b0;

      cnt_d = cnt_q;
      if (issue_ok && !retire_ok) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!issue_ok && retire_ok) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      err_d = err_q | (retire_i & ~retire_ok);

      state_d = state_q;
      case (state_q)
         StRun:   if (fence_req_i && !cnt_zero) state_d = StDrain;
         StDrain: if (cnt_zero) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         state_q   <= StRun;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         state_q   <= state_d;
      end
   end

   assign pend_rs1_o    = pending_q[rs1_addr_i];
   assign pend_rs2_o    = pending_q[rs2_addr_i];
   assign pend_rd_o     = pending_q[rd_addr_i];
   assign drain_o       = (state_q == StDrain);
   assign sb_full_o     = (cnt_q == MaxCnt);
   assign outstanding_o = cnt_q;
   assign sb_err_o      = err_q;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Forwarding selects and D-stage stall generation for the 5-stage core, combined
// with the long-latency scoreboard and fence drain.
module hazard_scoreboard_ctrl
   import core_hazard_pkg::*;
#(
   parameter int unsigned  REG_AW  = REG_AW_DEF,
   parameter int unsigned  MAX_OUT = 4,
   localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              D_valid,
   input  logic              D_use_rs1,
   input  logic              D_use_rs2,
   input  logic              D_br,
   input  logic              D_long,
   input  logic              D_fence,
   input  logic              D_RegWrite,
   input  logic [REG_AW-1:0] D_rs1_addr,
   input  logic [REG_AW-1:0] D_rs2_addr,
   input  logic [REG_AW-1:0] D_rd_addr,
   input  logic              E_use_rs1,
   input  logic              E_use_rs2,
   input  logic              E_MemRead,
   input  logic              E_RegWrite,
   input  logic [REG_AW-1:0] E_rs1_addr,
   input  logic [REG_AW-1:0] E_rs2_addr,
   input  logic [REG_AW-1:0] E_rd_addr,
   input  logic              M_MemRead,
   input  logic              M_RegWrite,
   input  logic [REG_AW-1:0] M_rd_addr,
   input  logic              W_RegWrite,
   input  logic [REG_AW-1:0] W_rd_addr,
   input  logic              lu_wb_valid,
   input  logic [REG_AW-1:0] lu_wb_rd,
   output logic [1:0]        forward_rs1,
   output logic [1:0]        forward_rs2,
   output logic [1:0]        br_forward_rs1,
   output logic [1:0]        br_forward_rs2,
   output logic              stall_D,
   output logic              sb_full,
   output logic [CNT_W-1:0]  outstanding,
   output logic              sb_err
);

   function automatic logic src_hit(input logic used, input logic [REG_AW-1:0] src,
                                    input logic wr, input logic [REG_AW-1:0] dst);
      return used & wr & (src != '0) & (src == dst);
   endfunction

   logic pend_rs1, pend_rs2, pend_rd, drain, issue, fence_req;
   logic d_hit_e, d_hit_m;
   logic stall_lu, stall_ab, stall_lb, stall_raw, stall_waw, stall_str, stall_fence;

   always_comb begin
      forward_rs1    = FWD_NONE;
      forward_rs2    = FWD_NONE;
      br_forward_rs1 = FWD_NONE;
      br_forward_rs2 = FWD_NONE;
      if (!rst) begin
         forward_rs1 = fwd_sel(src_hit(E_use_rs1, E_rs1_addr, M_RegWrite, M_rd_addr),
                               src_hit(E_use_rs1, E_rs1_addr, W_RegWrite, W_rd_addr));
         forward_rs2 = fwd_sel(src_hit(E_use_rs2, E_rs2_addr, M_RegWrite, M_rd_addr),
                               src_hit(E_use_rs2, E_rs2_addr, W_RegWrite, W_rd_addr));
         if (D_br) begin
            br_forward_rs1 = fwd_sel(src_hit(D_use_rs1, D_rs1_addr, M_RegWrite, M_rd_addr),
                                     src_hit(D_use_rs1, D_rs1_addr, W_RegWrite, W_rd_addr));
            br_forward_rs2 = fwd_sel(src_hit(D_use_rs2, D_rs2_addr, M_RegWrite, M_rd_addr),
                                     src_hit(D_use_rs2, D_rs2_addr, W_RegWrite, W_rd_addr));
         end
      end
   end

   always_comb begin
      // Address-only matches; the producer's qualifier is applied per stall source.
      d_hit_e = src_hit(D_use_rs1, D_rs1_addr, 1'b1, E_rd_addr) |
                src_hit(D_use_rs2, D_rs2_addr, 1'b1, E_rd_addr);
      d_hit_m = src_hit(D_use_rs1, D_rs1_addr, 1'b1, M_rd_addr) |
                src_hit(D_use_rs2, D_rs2_addr, 1'b1, M_rd_addr);

      stall_lu    = E_MemRead & d_hit_e;
      stall_ab    = D_br & E_RegWrite & d_hit_e;
      stall_lb    = D_br & M_MemRead & d_hit_m;
      stall_raw   = (D_use_rs1 & pend_rs1) | (D_use_rs2 & pend_rs2);
      stall_waw   = D_RegWrite & pend_rd;
      stall_str   = D_long & sb_full;
      // Released in the cycle the count hits zero, even while the FSM still says drain.
      stall_fence = (drain | D_fence) & (outstanding != '0);

      stall_D = ~rst & D_valid & (stall_lu | stall_ab | stall_lb | stall_raw |
                                  stall_waw | stall_str | stall_fence);

      issue     = D_valid & D_long & D_RegWrite & ~stall_D & (D_rd_addr != '0);
      fence_req = D_valid & D_fence;
   end

   hazard_scoreboard #(
      .REG_AW  (REG_AW),
      .MAX_OUT (MAX_OUT),
      .CNT_W   (CNT_W)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .issue_i       (issue),
      .issue_rd_i    (D_rd_addr),
      .retire_i      (lu_wb_valid),
      .retire_rd_i   (lu_wb_rd),
      .fence_req_i   (fence_req),
      .rs1_addr_i    (D_rs1_addr),
      .rs2_addr_i    (D_rs2_addr),
      .rd_addr_i     (D_rd_addr),
      .pend_rs1_o    (pend_rs1),
      .pend_rs2_o    (pend_rs2),
      .pend_rd_o     (pend_rd),
      .drain_o       (drain),
      .sb_full_o     (sb_full),
      .outstanding_o (outstanding),
      .sb_err_o      (sb_err)
   );

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed scenarios plus randomized cycles checked against a rule-level model
// of the hazard controller (pending set, in-flight count, drain flag).
module tb_hazard_scoreboard_ctrl;

   localparam int CNT_W = 3;
   localparam int MAX_OUT = 4;

   logic clk = 1'b0;
   logic rst;
   logic D_valid, D_use_rs1, D_use_rs2, D_br, D_long, D_fence, D_RegWrite;
   logic [4:0] D_rs1_addr, D_rs2_addr, D_rd_addr;
   logic E_use_rs1, E_use_rs2, E_MemRead, E_RegWrite;
   logic [4:0] E_rs1_addr, E_rs2_addr, E_rd_addr;
   logic M_MemRead, M_RegWrite, W_RegWrite, lu_wb_valid;
   logic [4:0] M_rd_addr, W_rd_addr, lu_wb_rd;
   logic [1:0] forward_rs1, forward_rs2, br_forward_rs1, br_forward_rs2;
   logic stall_D, sb_full, sb_err;
   logic [CNT_W-1:0] outstanding;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   bit m_pend[32];
   int m_cnt;
   bit m_drain;
   bit m_err;

   always #5 clk = ~clk;

   hazard_scoreboard_ctrl dut (
      .clk(clk), .rst(rst),
      .D_valid(D_valid), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .D_br(D_br),
      .D_long(D_long), .D_fence(D_fence), .D_RegWrite(D_RegWrite),
      .D_rs1_addr(D_rs1_addr), .D_rs2_addr(D_rs2_addr), .D_rd_addr(D_rd_addr),
      .E_use_rs1(E_use_rs1), .E_use_rs2(E_use_rs2), .E_MemRead(E_MemRead),
      .E_RegWrite(E_RegWrite), .E_rs1_addr(E_rs1_addr), .E_rs2_addr(E_rs2_addr),
      .E_rd_addr(E_rd_addr), .M_MemRead(M_MemRead), .M_RegWrite(M_RegWrite),
      .M_rd_addr(M_rd_addr), .W_RegWrite(W_RegWrite), .W_rd_addr(W_rd_addr),
      .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd),
      .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
      .br_forward_rs1(br_forward_rs1), .br_forward_rs2(br_forward_rs2),
      .stall_D(stall_D), .sb_full(sb_full), .outstanding(outstanding), .sb_err(sb_err)
   );

   task automatic clear_inputs();
      D_valid = 0; D_use_rs1 = 0; D_use_rs2 = 0; D_br = 0; D_long = 0; D_fence = 0;
      D_RegWrite = 0; D_rs1_addr = 0; D_rs2_addr = 0; D_rd_addr = 0;
      E_use_rs1 = 0; E_use_rs2 = 0; E_MemRead = 0; E_RegWrite = 0;
      E_rs1_addr = 0; E_rs2_addr = 0; E_rd_addr = 0;
      M_MemRead = 0; M_RegWrite = 0; M_rd_addr = 0; W_RegWrite = 0; W_rd_addr = 0;
      lu_wb_valid = 0; lu_wb_rd = 0;
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_cnt = 0;
      m_drain = 0;
      m_err = 0;
   endtask

   function automatic bit hit(input logic u, input logic [4:0] a, input logic [4:0] d);
      return u && a != 0 && a == d;
   endfunction

   function automatic logic [1:0] model_fwd(input logic u, input logic [4:0] a);
      if (rst) return 2'b00;
      if (M_RegWrite && hit(u, a, M_rd_addr)) return 2'b01;
      if (W_RegWrite && hit(u, a, W_rd_addr)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit model_stall();
      bit e_dep, m_dep, any;
      if (rst || !D_valid) return 0;
      e_dep = hit(D_use_rs1, D_rs1_addr, E_rd_addr) || hit(D_use_rs2, D_rs2_addr, E_rd_addr);
      m_dep = hit(D_use_rs1, D_rs1_addr, M_rd_addr) || hit(D_use_rs2, D_rs2_addr, M_rd_addr);
      any = (E_MemRead && e_dep) || (D_br && E_RegWrite && e_dep) ||
            (D_br && M_MemRead && m_dep) ||
            (D_use_rs1 && m_pend[D_rs1_addr]) || (D_use_rs2 && m_pend[D_rs2_addr]) ||
            (D_RegWrite && m_pend[D_rd_addr]) || (D_long && m_cnt == MAX_OUT) ||
            ((m_drain || D_fence) && m_cnt != 0);
      return any;
   endfunction

   // Advance the model with the inputs currently applied, then cross one edge.
   task automatic tick();
      bit iss, ok;
      if (rst) begin
         model_reset();
      end else begin
         iss = D_valid && D_long && D_RegWrite && !model_stall() && D_rd_addr != 0;
         ok = lu_wb_valid && m_pend[lu_wb_rd] && m_cnt > 0;
         if (lu_wb_valid && !ok) m_err = 1;
         if (!m_drain && D_valid && D_fence && m_cnt != 0) m_drain = 1;
         else if (m_drain && m_cnt == 0) m_drain = 0;
         if (ok) begin m_pend[lu_wb_rd] = 0; m_cnt--; end
         if (iss) begin m_pend[D_rd_addr] = 1; m_cnt++; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue_long(input logic [4:0] rd);
      clear_inputs();
      D_valid = 1; D_long = 1; D_RegWrite = 1; D_rd_addr = rd;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      E_use_rs1 = 1; E_rs1_addr = 5; M_RegWrite = 1; M_rd_addr = 5;
      D_valid = 1; D_use_rs1 = 1; D_rs1_addr = 5; E_MemRead = 1; E_RegWrite = 1; E_rd_addr = 5;
      #1;
      n_tests++; if (forward_rs1 !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b want 00", forward_rs1); end
      n_tests++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_D); end
      n_tests++; if (outstanding !== 0 || sb_full !== 1'b0 || sb_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_sb: out=%0d full=%b err=%b want 0 0 0", outstanding, sb_full, sb_err);
      end
      clear_inputs();
      rst = 0;
      model_reset();
      tick();
   endtask

   task automatic test_forward();
      clear_inputs();
      E_use_rs1 = 1; E_rs1_addr = 5; M_RegWrite = 1; M_rd_addr = 5; W_RegWrite = 1; W_rd_addr = 5;
      E_rs2_addr = 5; D_use_rs1 = 1; D_rs1_addr = 5;
      #1;
      n_tests++; if (forward_rs1 !== 2'b01) begin n_fail++; $display("FAIL fwd_m_prio: got %b want 01", forward_rs1); end
      n_tests++; if (forward_rs2 !== 2'b00) begin n_fail++; $display("FAIL fwd_unused: got %b want 00", forward_rs2); end
      n_tests++; if (br_forward_rs1 !== 2'b00) begin n_fail++; $display("FAIL brfwd_nobr: got %b want 00", br_forward_rs1); end
      M_RegWrite = 0; E_use_rs2 = 1;
      #1;
      n_tests++; if (forward_rs1 !== 2'b10) begin n_fail++; $display("FAIL fwd_w: got %b want 10", forward_rs1); end
      n_tests++; if (forward_rs2 !== 2'b10) begin n_fail++; $display("FAIL fwd_w_rs2: got %b want 10", forward_rs2); end
      E_rs1_addr = 0; M_RegWrite = 1; M_rd_addr = 0; W_rd_addr = 0;
      #1;
      n_tests++; if (forward_rs1 !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b want 00", forward_rs1); end
      tick();
   endtask

   task automatic test_branch_stall();
      clear_inputs();
      D_valid = 1; D_br = 1; D_use_rs1 = 1; D_rs1_addr = 6; D_use_rs2 = 1; D_rs2_addr = 3;
      E_MemRead = 1; E_RegWrite = 1; E_rd_addr = 6;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL lw_beq_c1: got %b want 1", stall_D); end
      tick();
      E_MemRead = 0; E_RegWrite = 0; E_rd_addr = 0; M_MemRead = 1; M_RegWrite = 1; M_rd_addr = 6;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL lw_beq_c2: got %b want 1", stall_D); end
      tick();
      M_MemRead = 0; M_RegWrite = 0; M_rd_addr = 0; W_RegWrite = 1; W_rd_addr = 6;
      #1;
      n_tests++; if (stall_D !== 1'b0 || br_forward_rs1 !== 2'b10) begin
         n_fail++; $display("FAIL lw_beq_c3: stall=%b brfwd=%b want 0 10", stall_D, br_forward_rs1);
      end
      tick();
      W_RegWrite = 0; E_RegWrite = 1; E_rd_addr = 6;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL add_beq_c1: got %b want 1", stall_D); end
      tick();
      E_RegWrite = 0; E_rd_addr = 0; M_RegWrite = 1; M_rd_addr = 6;
      #1;
      n_tests++; if (stall_D !== 1'b0 || br_forward_rs1 !== 2'b01 || br_forward_rs2 !== 2'b00) begin
         n_fail++; $display("FAIL add_beq_c2: stall=%b br1=%b br2=%b want 0 01 00", stall_D, br_forward_rs1, br_forward_rs2);
      end
      M_RegWrite = 0; D_br = 0; E_RegWrite = 1; E_rd_addr = 6;
      #1;
      n_tests++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL alu_alu_nostall: got %b want 0", stall_D); end
      tick();
   endtask

   task automatic test_long_raw();
      clear_inputs();
      D_valid = 1; D_long = 1; D_RegWrite = 1; D_rd_addr = 7;
      #1;
      n_tests++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL div_issue: got %b want 0", stall_D); end
      tick();
      clear_inputs();
      D_valid = 1; D_use_rs1 = 1; D_rs1_addr = 7; D_RegWrite = 1; D_rd_addr = 10;
      #1;
      n_tests++; if (stall_D !== 1'b1 || outstanding !== 3'd1) begin
         n_fail++; $display("FAIL raw_held: stall=%b out=%0d want 1 1", stall_D, outstanding);
      end
      tick();
      lu_wb_valid = 1; lu_wb_rd = 7;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL raw_nobypass: got %b want 1", stall_D); end
      tick();
      lu_wb_valid = 0;
      #1;
      n_tests++; if (stall_D !== 1'b0 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL raw_release: stall=%b out=%0d want 0 0", stall_D, outstanding);
      end
      tick();
   endtask

   task automatic test_full();
      logic [4:0] rds[3] = '{5'd3, 5'd4, 5'd8};
      for (int i = 1; i <= 4; i++) issue_long(5'(i));
      #1;
      n_tests++; if (sb_full !== 1'b1 || outstanding !== 3'd4) begin
         n_fail++; $display("FAIL full: full=%b out=%0d want 1 4", sb_full, outstanding);
      end
      D_valid = 1; D_long = 1; D_RegWrite = 1; D_rd_addr = 5;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL struct_stall: got %b want 1", stall_D); end
      tick();
      clear_inputs(); lu_wb_valid = 1; lu_wb_rd = 1;
      tick();
      D_valid = 1; D_long = 1; D_RegWrite = 1; D_rd_addr = 8; lu_wb_valid = 1; lu_wb_rd = 2;
      #1;
      n_tests++; if (stall_D !== 1'b0 || outstanding !== 3'd3) begin
         n_fail++; $display("FAIL iss_ret_pre: stall=%b out=%0d want 0 3", stall_D, outstanding);
      end
      tick();
      clear_inputs(); D_valid = 1; D_use_rs2 = 1; D_rs2_addr = 8;
      #1;
      n_tests++; if (outstanding !== 3'd3 || stall_D !== 1'b1) begin
         n_fail++; $display("FAIL iss_ret_same: out=%0d stall=%b want 3 1", outstanding, stall_D);
      end
      clear_inputs();
      for (int i = 0; i < 3; i++) begin lu_wb_valid = 1; lu_wb_rd = rds[i]; tick(); end
      clear_inputs();
      #1;
      n_tests++; if (outstanding !== 3'd0 || sb_err !== 1'b0) begin
         n_fail++; $display("FAIL full_drain: out=%0d err=%b want 0 0", outstanding, sb_err);
      end
   endtask

   task automatic test_fence();
      issue_long(11);
      issue_long(12);
      D_valid = 1; D_fence = 1;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL fence_enter: got %b want 1", stall_D); end
      tick();
      D_fence = 0; lu_wb_valid = 1; lu_wb_rd = 11;
      #1;
      n_tests++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL drain_hold: got %b want 1", stall_D); end
      tick();
      D_fence = 1; lu_wb_rd = 12;
      #1;
      n_tests++; if (stall_D !== 1'b1 || outstanding !== 3'd1) begin
         n_fail++; $display("FAIL drain_one: stall=%b out=%0d want 1 1", stall_D, outstanding);
      end
      tick();
      lu_wb_valid = 0;
      #1;
      n_tests++; if (stall_D !== 1'b0 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL drain_done: stall=%b out=%0d want 0 0", stall_D, outstanding);
      end
      tick();
      #1;
      n_tests++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL fence_idle: got %b want 0", stall_D); end
      clear_inputs(); lu_wb_valid = 1; lu_wb_rd = 9;
      tick();
      clear_inputs();
      #1;
      n_tests++; if (sb_err !== 1'b1 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL bad_retire: err=%b out=%0d want 1 0", sb_err, outstanding);
      end
   endtask

   task automatic test_reset_mid();
      issue_long(13);
      issue_long(14);
      issue_long(15);
      D_valid = 1; D_fence = 1;
      tick();
      E_use_rs1 = 1; E_rs1_addr = 5; M_RegWrite = 1; M_rd_addr = 5;
      #1;
      n_tests++; if (stall_D !== 1'b1 || outstanding !== 3'd3) begin
         n_fail++; $display("FAIL pre_reset: stall=%b out=%0d want 1 3", stall_D, outstanding);
      end
      #1;
      rst = 1;
      model_reset();
      #1;
      n_tests++; if (outstanding !== 0 || stall_D !== 1'b0 || forward_rs1 !== 2'b00 || sb_err !== 1'b0 || sb_full !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: out=%0d stall=%b fwd=%b err=%b full=%b want all 0",
                            outstanding, stall_D, forward_rs1, sb_err, sb_full);
      end
      @(negedge clk);
      rst = 0;
      tick();
      D_fence = 0; D_use_rs1 = 1; D_rs1_addr = 13;
      #1;
      n_tests++; if (stall_D !== 1'b0 || forward_rs1 !== 2'b01) begin
         n_fail++; $display("FAIL post_reset: stall=%b fwd=%b want 0 01", stall_D, forward_rs1);
      end
      D_fence = 1;
      #1;
      n_tests++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL post_reset_fence: got %b want 0", stall_D); end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      logic [1:0] e1, e2, b1, b2;
      for (int c = 0; c < 500; c++) begin
         D_valid = ($urandom_range(0, 9) != 0);
         D_use_rs1 = 1'($urandom()); D_use_rs2 = 1'($urandom());
         D_br = ($urandom_range(0, 2) == 0); D_long = ($urandom_range(0, 2) == 0);
         D_fence = ($urandom_range(0, 7) == 0); D_RegWrite = 1'($urandom());
         D_rs1_addr = 5'($urandom_range(0, 7)); D_rs2_addr = 5'($urandom_range(0, 7));
         D_rd_addr = 5'($urandom_range(0, 7));
         E_use_rs1 = 1'($urandom()); E_use_rs2 = 1'($urandom());
         E_MemRead = ($urandom_range(0, 3) == 0); E_RegWrite = E_MemRead | 1'($urandom());
         E_rs1_addr = 5'($urandom_range(0, 7)); E_rs2_addr = 5'($urandom_range(0, 7));
         E_rd_addr = 5'($urandom_range(0, 7));
         M_MemRead = ($urandom_range(0, 3) == 0); M_RegWrite = M_MemRead | 1'($urandom());
         M_rd_addr = 5'($urandom_range(0, 7));
         W_RegWrite = 1'($urandom()); W_rd_addr = 5'($urandom_range(0, 7));
         lu_wb_valid = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) begin
            lu_wb_rd = 5'($urandom_range(0, 7));
         end else begin
            lu_wb_rd = 5'($urandom_range(1, 7));
            for (int k = 0; k < 7; k++)
               if (!m_pend[lu_wb_rd]) lu_wb_rd = (lu_wb_rd == 7) ? 5'd1 : lu_wb_rd + 5'd1;
         end
         #1;
         e1 = model_fwd(E_use_rs1, E_rs1_addr);
         e2 = model_fwd(E_use_rs2, E_rs2_addr);
         b1 = D_br ? model_fwd(D_use_rs1, D_rs1_addr) : 2'b00;
         b2 = D_br ? model_fwd(D_use_rs2, D_rs2_addr) : 2'b00;
         n_tests++; if (forward_rs1 !== e1 || forward_rs2 !== e2) begin
            n_fail++; $display("FAIL rnd_fwd c%0d: got %b/%b want %b/%b", c, forward_rs1, forward_rs2, e1, e2);
         end
         n_tests++; if (br_forward_rs1 !== b1 || br_forward_rs2 !== b2) begin
            n_fail++; $display("FAIL rnd_brfwd c%0d: got %b/%b want %b/%b", c, br_forward_rs1, br_forward_rs2, b1, b2);
         end
         n_tests++; if (stall_D !== model_stall()) begin
            n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_D, model_stall());
         end
         n_tests++; if (outstanding !== CNT_W'(m_cnt) || sb_full !== (m_cnt == MAX_OUT)) begin
            n_fail++; $display("FAIL rnd_cnt c%0d: out=%0d full=%b want %0d", c, outstanding, sb_full, m_cnt);
         end
         n_tests++; if (sb_err !== m_err) begin
            n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, sb_err, m_err);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_forward();
      test_branch_stall();
      test_long_raw();
      test_full();
      test_fence();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
